// File: rtl/window_3x3_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : window_3x3_gen_if
// Purpose  : Bundles the pixel input handshake and the registered 3x3 window
//            output of window_3x3_gen.
// Signals  : in_valid/in_ready/in_pixel  - raster pixel stream into the block
//            out_valid, p0..p8           - window, row-major, p4 is the centre
//            out_x/out_y                 - centre coordinates
//            out_sof/out_eof             - first / last window of the frame
// Modports : master - pixel source and window consumer side
//            slave  - window generator side
// Revision : 1.0 - initial release
// ============================================================================
interface window_3x3_gen_if #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = 8
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;

  logic              out_valid;
  logic [DATA_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic              out_sof;
  logic              out_eof;

  modport master (
    output in_valid, in_pixel,
    input  in_ready,
    input  out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
    input  out_x, out_y, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready,
    output out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
    output out_x, out_y, out_sof, out_eof
  );
endinterface
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_3x3_gen
// Purpose  : Converts a raster pixel stream into one zero-padded 3x3 window per
//            image pixel, centred on that pixel, using two line delays.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            win   - window_3x3_gen_if.slave (input stream + window output)
// Revision : 1.0 - initial release
// ============================================================================
module window_3x3_gen #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  window_3x3_gen_if.slave  win
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  // Slot counter spans 0 .. IMG_W*IMG_H+IMG_W inclusive.
  localparam int N_W = $clog2(IMG_W*IMG_H + IMG_W + 1);

  localparam logic [N_W-1:0] c_n_fill_last  = N_W'(IMG_W);
  localparam logic [N_W-1:0] c_n_run_last   = N_W'(IMG_W*IMG_H - 1);
  localparam logic [N_W-1:0] c_n_flush_last = N_W'(IMG_W*IMG_H + IMG_W);
  localparam logic [X_W-1:0] c_x_last       = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] c_y_last       = Y_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [N_W-1:0]    r_n;
  logic [X_W-1:0]    r_ptr;
  logic [X_W-1:0]    r_cx;
  logic [Y_W-1:0]    r_cy;

  // Line delays: r_lb1 returns the pixel one line back, r_lb2 two lines back.
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_lb2 [IMG_W];
  logic [DATA_W-1:0] w_lb1;
  logic [DATA_W-1:0] w_lb2;

  // Two previous window columns; the third (newest) column comes straight
  // from the incoming slot and the line-delay outputs.
  logic [DATA_W-1:0] r_c0_t, r_c0_m, r_c0_b;
  logic [DATA_W-1:0] r_c1_t, r_c1_m, r_c1_b;

  logic              w_take;
  logic              w_emit;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_data;
  logic              w_mask_t, w_mask_b, w_mask_l, w_mask_r;
  logic [DATA_W-1:0] w_win  [9];
  logic [DATA_W-1:0] w_winm [9];

  logic              r_out_valid;
  logic [DATA_W-1:0] r_p [9];
  logic [X_W-1:0]    r_out_x;
  logic [Y_W-1:0]    r_out_y;
  logic              r_sof;
  logic              r_eof;

  assign w_lb1 = r_lb1[r_ptr];
  assign w_lb2 = r_lb2[r_ptr];

  // --------------------------------------------------------------------------
  // Slot control and next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_take      = (r_state == ST_FLUSH) || win.in_valid;
    w_data      = (r_state == ST_FLUSH) ? '0 : win.in_pixel;
    w_emit      = w_take && (r_state != ST_FILL);
    w_frame_end = (r_state == ST_FLUSH) && (r_n == c_n_flush_last);
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FILL:  if (w_take && (r_n == c_n_fill_last)) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_take && (r_n == c_n_run_last))  w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_frame_end)                      w_state_nxt = ST_FILL;
      default:                                        w_state_nxt = ST_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Window assembly and zero padding from the centre coordinates. Padding
  // also hides whatever the line delays still hold from a previous frame.
  // --------------------------------------------------------------------------
  always_comb begin
    w_win[0] = r_c0_t;  w_win[1] = r_c1_t;  w_win[2] = w_lb2;
    w_win[3] = r_c0_m;  w_win[4] = r_c1_m;  w_win[5] = w_lb1;
    w_win[6] = r_c0_b;  w_win[7] = r_c1_b;  w_win[8] = w_data;

    w_mask_t = (r_cy == '0);
    w_mask_b = (r_cy == c_y_last);
    w_mask_l = (r_cx == '0);
    w_mask_r = (r_cx == c_x_last);

    for (int k = 0; k < 9; k++) begin
      w_winm[k] = w_win[k];
      if (((k / 3) == 0) && w_mask_t) w_winm[k] = '0;
      if (((k / 3) == 2) && w_mask_b) w_winm[k] = '0;
      if (((k % 3) == 0) && w_mask_l) w_winm[k] = '0;
      if (((k % 3) == 2) && w_mask_r) w_winm[k] = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State, counters, shift columns and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_n         <= '0;
      r_ptr       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_c0_t      <= '0;
      r_c0_m      <= '0;
      r_c0_b      <= '0;
      r_c1_t      <= '0;
      r_c1_m      <= '0;
      r_c1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      for (int k = 0; k < 9; k++) r_p[k] <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_take) begin
        r_n    <= w_frame_end ? '0 : r_n + 1'b1;
        r_ptr  <= (w_frame_end || (r_ptr == c_x_last)) ? '0 : r_ptr + 1'b1;
        r_c0_t <= r_c1_t;
        r_c0_m <= r_c1_m;
        r_c0_b <= r_c1_b;
        r_c1_t <= w_lb2;
        r_c1_m <= w_lb1;
        r_c1_b <= w_data;
      end

      // Centre coordinates walk the image once per frame and land back on
      // (0,0) exactly when the last window is emitted.
      if (w_emit) begin
        if (r_cx == c_x_last) begin
          r_cx <= '0;
          r_cy <= (r_cy == c_y_last) ? '0 : r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end

      r_out_valid <= w_emit;
      r_sof       <= w_emit && w_mask_t && w_mask_l;
      r_eof       <= w_emit && w_mask_b && w_mask_r;
      if (w_emit) begin
        r_out_x <= r_cx;
        r_out_y <= r_cy;
        for (int k = 0; k < 9; k++) r_p[k] <= w_winm[k];
      end
    end
  end

  // Line-delay storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_lb1[r_ptr] <= w_data;
      r_lb2[r_ptr] <= w_lb1;
    end
  end

  assign win.in_ready  = (r_state != ST_FLUSH);
  assign win.out_valid = r_out_valid;
  assign win.out_x     = r_out_x;
  assign win.out_y     = r_out_y;
  assign win.out_sof   = r_sof;
  assign win.out_eof   = r_eof;
  assign win.p0        = r_p[0];
  assign win.p1        = r_p[1];
  assign win.p2        = r_p[2];
  assign win.p3        = r_p[3];
  assign win.p4        = r_p[4];
  assign win.p5        = r_p[5];
  assign win.p6        = r_p[6];
  assign win.p7        = r_p[7];
  assign win.p8        = r_p[8];

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_3x3_gen
// Purpose  : Directed self-checking bench for window_3x3_gen on a 4x3 image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_3x3_gen;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;

  logic clk;
  logic rst_n;

  window_3x3_gen_if #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) bus ();

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .win   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cap [W*H][9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] port_p(input int k);
    case (k)
      0: port_p = 32'(bus.p0);
      1: port_p = 32'(bus.p1);
      2: port_p = 32'(bus.p2);
      3: port_p = 32'(bus.p3);
      4: port_p = 32'(bus.p4);
      5: port_p = 32'(bus.p5);
      6: port_p = 32'(bus.p6);
      7: port_p = 32'(bus.p7);
      default: port_p = 32'(bus.p8);
    endcase
  endfunction

  // Reference image value with zero outside the frame.
  function automatic int pix(input int base, input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) pix = 0;
    else pix = base + r * W + c + 1;
  endfunction

  task automatic check_win(input string tag, input int m, input int e[9]);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s_p%0d", tag, k), cap[m][k], e[k]);
  endtask

  // Streams one frame (values base+1 ..), optionally with a 1,0,0,1 in_valid
  // pattern, and checks every cycle against the reference model.
  task automatic run_frame(input int base, input bit gaps);
    int   acc, emitted, cyc, ph, m, cx, cy, vcnt;
    logic exp_ready, exp_valid, xfer, flushing;
    acc = 0; emitted = 0; cyc = 0; ph = 0; vcnt = 0;
    while (emitted < W*H && cyc < 200) begin
      bus.in_valid = (acc < W*H) && (!gaps || (ph % 4 == 0) || (ph % 4 == 3));
      bus.in_pixel = DW'(base + acc + 1);
      ph++;
      exp_ready = (acc != W*H);
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      xfer     = bus.in_valid && exp_ready;
      flushing = !exp_ready;
      @(posedge clk); #1;
      cyc++;
      if (xfer) acc++;
      exp_valid = (xfer && acc >= W + 2) || flushing;
      check($sformatf("out_valid_c%0d", cyc), 32'(bus.out_valid), 32'(exp_valid));
      if (bus.out_valid === 1'b1) vcnt++;
      if (exp_valid) begin
        m  = emitted;
        cx = m % W;
        cy = m / W;
        for (int k = 0; k < 9; k++) begin
          cap[m][k] = int'(port_p(k));
          check($sformatf("win%0d_p%0d", m, k), port_p(k), pix(base, cy - 1 + k / 3, cx - 1 + k % 3));
        end
        check($sformatf("win%0d_x", m), 32'(bus.out_x), cx);
        check($sformatf("win%0d_y", m), 32'(bus.out_y), cy);
        check($sformatf("win%0d_sof", m), 32'(bus.out_sof), (m == 0) ? 1 : 0);
        check($sformatf("win%0d_eof", m), 32'(bus.out_eof), (m == W*H - 1) ? 1 : 0);
        emitted++;
      end
    end
    bus.in_valid = 1'b0;
    check("frame_windows_emitted", emitted, W*H);
    check("frame_out_valid_count", vcnt, W*H);
    check("ready_after_frame", 32'(bus.in_ready), 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready",  32'(bus.in_ready),  1);
    check("rst_p4",        port_p(4),          0);
    check("rst_sof",       32'(bus.out_sof),   0);
    check("rst_eof",       32'(bus.out_eof),   0);
    check("rst_x",         32'(bus.out_x),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_out_valid", 32'(bus.out_valid), 0);

    // Gapless ramp frame: corner, interior and last-corner windows
    run_frame(0, 1'b0);
    check_win("A_corner00",  0,  '{0, 0, 0, 0, 1, 2, 0, 5, 6});
    check_win("A_inter11",   5,  '{1, 2, 3, 5, 6, 7, 9, 10, 11});
    check_win("A_last23",    11, '{7, 8, 0, 11, 12, 0, 0, 0, 0});

    // Back-to-back second frame with different values
    run_frame(100, 1'b0);
    check_win("B_corner00",  0,  '{0, 0, 0, 0, 101, 102, 0, 105, 106});
    check_win("B_last23",    11, '{107, 108, 0, 111, 112, 0, 0, 0, 0});

    // Frame with input gaps
    run_frame(0, 1'b1);
    check_win("C_corner00",  0,  '{0, 0, 0, 0, 1, 2, 0, 5, 6});
    check_win("C_inter11",   5,  '{1, 2, 3, 5, 6, 7, 9, 10, 11});
    check_win("C_last23",    11, '{7, 8, 0, 11, 12, 0, 0, 0, 0});

    // Mid-frame reset after 7 pixels
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = DW'(i + 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    check("pre_rst_x",     32'(bus.out_x),     1);
    check("pre_rst_p4",    port_p(4),          2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_x",     32'(bus.out_x),     0);
    check("async_rst_p4",    port_p(4),          0);
    check("async_rst_ready", 32'(bus.in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 1'b0);
    check_win("D_corner00",  0,  '{0, 0, 0, 0, 1, 2, 0, 5, 6});
    check_win("D_last23",    11, '{7, 8, 0, 11, 12, 0, 0, 0, 0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
